uart_tx_engine: RTL
===================

# uart_tx_engine

Buffered, parametrised UART transmitter for the single-clock fabric. It accepts characters over a valid/ready handshake into an internal FIFO and serialises them LSB-first with start, optional parity and 1 or 2 stop bits. Bit timing comes from an in-domain clock-enable divider, so no derived clocks are used. It replaces the fixed 8N1 serialiser at the board-level UART port.

## Interface
- CLK_DIV, 4096: system clocks per bit; ≥2.
- CHAR_W, 8: data bits per character; 5..9.
- STOP_BITS, 1: stop bits; 1 or 2 only.
- FIFO_DEPTH, 4: character buffer entries; power of two, ≥2.
- clock_50M  in  1  system clock; all logic on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  tx_data holds a character to send.
- tx_data  in  CHAR_W  character; bit 0 is transmitted first.
- tx_ready  out  1  FIFO can accept; high when not full.
- parity_mode  in  2  uart_pkg::parity_e: 0 none, 1 odd, 2 even, 3 reserved (treated as none).
- tx_busy  out  1  frame in progress or FIFO non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- uart_tx_pin  out  1  serial line; idle high.

## Operation
- Reset: uart_tx_pin=1, tx_busy=0, tx_ready=1, fifo_count=0. FIFO is emptied and the FSM enters IDLE. Assertion mid-frame drives the pin high at once and drops the character.
- Push: tx_valid&&tx_ready at a rising edge writes tx_data and increments fifo_count. tx_valid while full is ignored, with no overwrite.
- Full FIFO: tx_ready is low even if a pop happens in the same cycle. No bypass.
- Simultaneous push and pop: fifo_count is unchanged.
- FSM states (uart_pkg::tx_state_e): IDLE, START, DATA, PARITY, STOP.
  - IDLE: FIFO non-empty → pop into shift register, latch parity_mode, clear bit-cycle counter, go START.
  - START: pin=0 for CLK_DIV cycles → DATA.
  - DATA: pin=shift[0] for CLK_DIV cycles per bit, shift right, CHAR_W bits → PARITY if latched mode is odd/even, else STOP.
  - PARITY: pin = XOR of the data bits for even, or its inverse for odd; CLK_DIV cycles → STOP.
  - STOP: pin=1 for STOP_BITS×CLK_DIV cycles. At the end, FIFO non-empty → pop and go directly to START with no idle gap; else IDLE.
- parity_mode changes mid-frame affect only the next frame.
- Bit-cycle counter: $clog2(CLK_DIV) bits, counts 0..CLK_DIV-1 and wraps. A bit boundary occurs at CLK_DIV-1. The counter is held at 0 in IDLE.
- Bit index counter: $clog2(CHAR_W+1) bits.
- tx_busy = (state!=IDLE) || fifo_count!=0.

## Timing
- Push on edge E0 into an empty FIFO while IDLE:
  - fifo_count=1 after E0.
  - Pop on E1: pin=0 and fifo_count=0 after E1.
- Frame length is CLK_DIV×(1+CHAR_W+P+STOP_BITS) cycles, where P is 1 if parity is enabled, else 0. Each bit is exactly CLK_DIV cycles with no jitter.
- Back-to-back: the next start bit begins on the cycle after the final stop cycle.
- tx_ready falls on the edge where fifo_count reaches FIFO_DEPTH and rises on the edge of the pop that frees a slot.
- All outputs are registered except tx_ready and tx_busy, which are combinational from registers.

## Structure
- uart_pkg holds:
  - parity_e enum: PAR_NONE, PAR_ODD, PAR_EVEN, PAR_RSVD.
  - tx_state_e enum.
  - Function frame_bits(CHAR_W, parity, STOP_BITS).
- Sub-module uart_tx_fifo (parameters CHAR_W, FIFO_DEPTH):
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Pointers carry one extra wrap bit, and full/empty are decoded from it.
  - rdata is valid combinationally whenever empty is low.
- Top level contains the FSM, the bit-cycle and bit-index counters, the shift register and the parity accumulator.

## Test plan
All scenarios use CLK_DIV=4, CHAR_W=8.
- Reset: hold n_reset low → pin=1, tx_ready=1, tx_busy=0, fifo_count=0.
- 8N1, push 0xA5 → after E1 the pin carries 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. tx_busy falls after 40 cycles.
- Parity, 0xA5 (four ones) → the bit after the data is 0 with parity_mode=2 (even) and 1 with parity_mode=1 (odd). Frame is 44 cycles.
- Full FIFO, FIFO_DEPTH=4, hold tx_valid with 0x01..0x06 → first pop frees a slot, so 5 accepted. tx_ready is low while count=4 and the 6th is accepted only after the next pop. Frames are contiguous with no idle cycles between stop and start.
- STOP_BITS=2, push 0x00 → the stop level is held 8 cycles. Frame is 44 cycles.
- Reset mid-frame: assert n_reset during bit 3 of 0xFF → pin=1 on the same cycle, fifo_count=0, and after release no residual frame appears.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the buffered UART transmitter.
// Holds the parity mode enum, the FSM state enum and a frame-length helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2,
        PAR_RSVD = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Bits on the line for one character; the reserved mode sends no parity.
    function automatic int frame_bits(
        input int      char_w,
        input parity_e parity,
        input int      stop_bits
    );
        int p;
        p = (parity == PAR_ODD || parity == PAR_EVEN) ? 1 : 0;
        return 1 + char_w + p + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: character buffer between the handshake and the serialiser.
// Ports: clk/rst_n, push/wdata in, pop/rdata out, full, empty, count.
module uart_tx_fifo #(
    parameter int CHAR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [CHAR_W-1:0]             wdata,
    output logic [CHAR_W-1:0]             rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [CHAR_W-1:0] mem [FIFO_DEPTH];
    logic              do_push;
    logic              do_pop;

    // Pointers carry a wrap bit: equal low bits with differing wrap bits
    // means the writer has lapped the reader.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: buffered UART transmitter, LSB first, optional parity.
// Ports: tx_valid/tx_data/tx_ready push side, parity_mode, tx_busy,
// fifo_count and the idle-high serial output uart_tx_pin.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 4096,
    parameter int CHAR_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock_50M,
    input  logic                        n_reset,
    input  logic                        tx_valid,
    input  logic [CHAR_W-1:0]           tx_data,
    output logic                        tx_ready,
    input  parity_e                     parity_mode,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        uart_tx_pin
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(CHAR_W + 1);

    tx_state_e         state, state_d;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [IDX_W-1:0]  bit_idx, bit_idx_d;
    logic [CHAR_W-1:0] shift, shift_d;
    logic              par_acc, par_acc_d;
    parity_e           mode, mode_d;
    logic              pin_d;

    logic              full;
    logic              empty;
    logic              pop;
    logic [CHAR_W-1:0] rdata;
    logic              tick;
    logic              par_en;

    // A slot freed by a pop in the same cycle is not reused until next cycle.
    assign tx_ready = !full;
    assign tx_busy  = (state != IDLE) || (fifo_count != '0);

    uart_tx_fifo #(
        .CHAR_W     (CHAR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clock_50M),
        .rst_n (n_reset),
        .push  (tx_valid && tx_ready),
        .pop   (pop),
        .wdata (tx_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign tick   = (bit_cnt == CNT_W'(CLK_DIV - 1));
    assign par_en = (mode == PAR_ODD) || (mode == PAR_EVEN);

    always_ff @(posedge clock_50M or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_acc     <= 1'b0;
            mode        <= PAR_NONE;
            uart_tx_pin <= 1'b1;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            bit_idx     <= bit_idx_d;
            shift       <= shift_d;
            par_acc     <= par_acc_d;
            mode        <= mode_d;
            uart_tx_pin <= pin_d;
        end
    end

    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        par_acc_d = par_acc;
        mode_d    = mode;
        pop       = 1'b0;
        if (state == IDLE || tick) bit_cnt_d = '0;
        else                       bit_cnt_d = bit_cnt + CNT_W'(1);

        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = rdata;
                    mode_d    = parity_mode;
                    par_acc_d = 1'b0;
                    bit_idx_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift >> 1;
                    par_acc_d = par_acc ^ shift[0];
                    bit_idx_d = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(CHAR_W - 1)) begin
                        bit_idx_d = '0;
                        state_d   = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    bit_idx_d = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        // Chain straight into the next start bit.
                        if (!empty) begin
                            pop       = 1'b1;
                            shift_d   = rdata;
                            mode_d    = parity_mode;
                            par_acc_d = 1'b0;
                            state_d   = START;
                        end else begin
                            state_d   = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin is registered from the next-cycle state so each level
        // appears on the same edge that enters its state.
        unique case (state_d)
            START:   pin_d = 1'b0;
            DATA:    pin_d = shift_d[0];
            PARITY:  pin_d = par_acc_d ^ (mode_d == PAR_ODD);
            default: pin_d = 1'b1;
        endcase
    end

endmodule
